// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM path.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } mem_state_e;

  localparam int unsigned DEF_BASE_ADDR = 1024;
  localparam int unsigned DEF_SRAM_AW   = 18;
  localparam int unsigned HALF_W        = 16;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: counts 0..WAIT_CYCLES-1, flags the last cycle and wraps.
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/sram_controller.sv
// Splits one 32-bit MEM-stage load/store into two 16-bit async SRAM accesses
// and stalls the pipeline through ready while the access is in flight.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic [31:0]         address,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data,
  output logic                ready,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [HALF_W-1:0]   sram_dq_out,
  output logic                sram_dq_oe,
  input  logic [HALF_W-1:0]   sram_dq_in,
  output logic                sram_we_n
);

  localparam int unsigned WORD_W = SRAM_AW - 1;

  mem_state_e state_q, state_d;

  logic               req;
  logic               tc;
  logic               cnt_clr;
  logic               cnt_en;
  logic               op_wr_q;
  logic [WORD_W-1:0]  word_q;
  logic [HALF_W-1:0]  data_hi_q;
  logic [31:0]        off_in;
  logic               unused_off_bits;

  assign req     = rd_en | wr_en;
  assign off_in  = address - BASE_ADDR;
  assign cnt_clr = (state_q == IDLE) || (state_q == DONE);
  assign cnt_en  = (state_q == LOW) || (state_q == HIGH);

  // Byte-lane bits and bits above the SRAM range are dropped; addresses wrap.
  assign unused_off_bits = ^{off_in[31:SRAM_AW+1], off_in[1:0]};

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .tc (tc)
  );

  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) state_d = LOW;
      end
      LOW, HIGH: begin
        // Strobe released on the last cycle so address/data are held past we_n rising.
        sram_dq_oe = op_wr_q;
        sram_we_n  = ~(op_wr_q & ~tc);
        if (tc) state_d = (state_q == LOW) ? HIGH : DONE;
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus address/data are registered one cycle ahead so they are stable for the whole phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_wr_q     <= 1'b0;
      word_q      <= '0;
      data_hi_q   <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req) begin
            op_wr_q   <= wr_en;
            word_q    <= off_in[SRAM_AW:2];
            data_hi_q <= write_data[31:HALF_W];
            sram_addr <= {off_in[SRAM_AW:2], 1'b0};
            if (wr_en) sram_dq_out <= write_data[HALF_W-1:0];
          end
        end
        LOW: begin
          if (tc) begin
            sram_addr <= {word_q, 1'b1};
            if (op_wr_q) sram_dq_out <= data_hi_q;
            else         read_data[HALF_W-1:0] <= sram_dq_in;
          end
        end
        HIGH: begin
          if (tc && !op_wr_q) read_data[31:HALF_W] <= sram_dq_in;
        end
        default: ;
      endcase
    end
  end

endmodule
